hpm_counter_bank: RTL

- Parametrised hardware performance-monitor counter bank; the next generation of the core's fixed HPM counters.
- Sits beside the CSR file in the core top level. Takes per-lane event flags from the datapath and core-external events from the PMU interface.
- Provides mcycle, minstret, N programmable mhpmcounters with event selectors, mcountinhibit and sticky overflow status.
- Accessed through the CSR file's perf address/data/we port.

---
 rtl/hpm_pkg.sv | 36 +++
 rtl/hpm_event_mux.sv | 33 +++
 rtl/hpm_counter_bank.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/hpm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hpm_pkg
//  Description : Shared CSR address map, event code enumeration and event
//                selector type for the HPM counter bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package hpm_pkg;

    // CSR address map
    localparam logic [11:0] HPM_MCYCLE_ADDR   = 12'hB00;
    localparam logic [11:0] HPM_MINSTRET_ADDR = 12'hB02;
    localparam logic [11:0] HPM_CNT_BASE      = 12'hB00;  // mhpmcounterK at base+K
    localparam logic [11:0] HPM_EVT_BASE      = 12'h320;  // mhpmeventK at base+K
    localparam logic [11:0] HPM_INHIBIT_ADDR  = 12'h320;
    localparam logic [11:0] HPM_OVF_ADDR      = 12'h7C0;
    localparam logic [11:0] HPM_OVFEN_ADDR    = 12'h7C1;

    // Widest selector the bank supports; enough for up to 255 event codes
    localparam int HPM_EVSEL_MAX_W = 8;

    typedef logic [HPM_EVSEL_MAX_W-1:0] hpm_evsel_t;

    // Well-known event codes; code 0 never counts
    typedef enum logic [HPM_EVSEL_MAX_W-1:0] {
        HPM_EV_NONE        = 8'd0,
        HPM_EV_LOAD        = 8'd1,
        HPM_EV_STORE       = 8'd2,
        HPM_EV_BRANCH      = 8'd3,
        HPM_EV_BRANCH_MISS = 8'd4,
        HPM_EV_ICACHE_MISS = 8'd5,
        HPM_EV_DCACHE_MISS = 8'd6
    } hpm_event_e;

endpackage : hpm_pkg
`default_nettype wire

// File: rtl/hpm_event_mux.sv
`default_nettype none
// ============================================================================
//  Module      : hpm_event_mux
//  Description : Selects one event code across all lanes and returns how many
//                lanes flagged it this cycle (0..NUM_LANES). Combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpm_event_mux
    import hpm_pkg::*;
#(
    parameter int NUM_EVENTS = 32,
    parameter int NUM_LANES  = 2,
    parameter int INC_W      = $clog2(NUM_LANES + 1)
) (
    input  hpm_evsel_t                      i_sel,
    input  logic [NUM_LANES*NUM_EVENTS-1:0] i_events,
    output logic [INC_W-1:0]                o_inc
);

    // Per lane at most one code matches; code 0 matches nothing
    always_comb begin
        o_inc = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int e = 1; e <= NUM_EVENTS; e++) begin
                if ((i_sel == hpm_evsel_t'(e)) && i_events[l*NUM_EVENTS + e - 1]) begin
                    o_inc = o_inc + INC_W'(1);
                end
            end
        end
    end

endmodule : hpm_event_mux
`default_nettype wire

// File: rtl/hpm_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : hpm_counter_bank
//  Description : mcycle, minstret and NUM_COUNTERS programmable HPM counters
//                with event selectors, mcountinhibit and sticky overflow.
//                Optional macro HPM_OVF_IRQ_EN adds mhpmovfen (0x7C1) and a
//                registered overflow interrupt on irq_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpm_counter_bank
    import hpm_pkg::*;
#(
    parameter int NUM_COUNTERS = 8,
    parameter int NUM_EVENTS   = 32,
    parameter int NUM_LANES    = 2,
    parameter int CNT_WIDTH    = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [11:0]                     addr_i,
    input  logic                            we_i,
    input  logic [63:0]                     data_i,
    output logic [63:0]                     data_o,
    input  logic [NUM_LANES*NUM_EVENTS-1:0] events_i,
    input  logic [NUM_LANES-1:0]            retire_i,
    output logic [NUM_COUNTERS-1:0]         ovf_o,
    output logic                            irq_o
);

    localparam int INC_W   = $clog2(NUM_LANES + 1);
    localparam int EVSEL_W = $clog2(NUM_EVENTS + 1);
    localparam int INH_W   = 3 + NUM_COUNTERS;

    logic [CNT_WIDTH-1:0] r_mcycle;
    logic [CNT_WIDTH-1:0] r_minstret;
    logic [CNT_WIDTH-1:0] r_cnt   [NUM_COUNTERS];
    logic [EVSEL_W-1:0]   r_evsel [NUM_COUNTERS];
    logic [INH_W-1:0]     r_inhibit;
    logic [NUM_COUNTERS-1:0] r_ovf;
    logic [63:0]          r_rdata;

    logic [INC_W-1:0]     w_inc   [NUM_COUNTERS];
    logic [CNT_WIDTH:0]   w_sum   [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] w_wr_cnt;
    logic [NUM_COUNTERS-1:0] w_wr_evt;
    logic [NUM_COUNTERS-1:0] w_ovf_set;
    logic [NUM_COUNTERS-1:0] w_ovf_clr;
    logic [INC_W-1:0]     w_ret_cnt;
    logic [EVSEL_W-1:0]   w_sel_wr;
    logic [63:0]          w_rdata;

    // Out-of-range selector writes collapse to "no event"
    assign w_sel_wr  = (data_i > 64'(NUM_EVENTS)) ? '0 : data_i[EVSEL_W-1:0];
    assign w_ovf_clr = (we_i && (addr_i == HPM_OVF_ADDR)) ? data_i[NUM_COUNTERS-1:0] : '0;

    // Retired-instruction count across lanes
    always_comb begin
        w_ret_cnt = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_ret_cnt = w_ret_cnt + INC_W'(retire_i[l]);
        end
    end

    generate
        for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_cnt
            hpm_event_mux #(
                .NUM_EVENTS (NUM_EVENTS),
                .NUM_LANES  (NUM_LANES),
                .INC_W      (INC_W)
            ) u_mux (
                .i_sel    (hpm_evsel_t'(r_evsel[k])),
                .i_events (events_i),
                .o_inc    (w_inc[k])
            );

            assign w_wr_cnt[k]  = we_i && (addr_i == HPM_CNT_BASE + 12'(k + 3));
            assign w_wr_evt[k]  = we_i && (addr_i == HPM_EVT_BASE + 12'(k + 3));
            assign w_sum[k]     = {1'b0, r_cnt[k]} + (CNT_WIDTH + 1)'(w_inc[k]);
            // A counter write discards this cycle's increment, carry included
            assign w_ovf_set[k] = !w_wr_cnt[k] && !r_inhibit[k + 3] && w_sum[k][CNT_WIDTH];
        end
    endgenerate

    // Counter, selector, inhibit and overflow state; writes take priority
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
            r_inhibit  <= '0;
            r_ovf      <= '0;
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                r_cnt[k]   <= '0;
                r_evsel[k] <= '0;
            end
        end else begin
            if (we_i && (addr_i == HPM_MCYCLE_ADDR)) begin
                r_mcycle <= data_i[CNT_WIDTH-1:0];
            end else if (!r_inhibit[0]) begin
                r_mcycle <= r_mcycle + CNT_WIDTH'(1);
            end

            if (we_i && (addr_i == HPM_MINSTRET_ADDR)) begin
                r_minstret <= data_i[CNT_WIDTH-1:0];
            end else if (!r_inhibit[2]) begin
                r_minstret <= r_minstret + CNT_WIDTH'(w_ret_cnt);
            end

            for (int k = 0; k < NUM_COUNTERS; k++) begin
                if (w_wr_cnt[k]) begin
                    r_cnt[k] <= data_i[CNT_WIDTH-1:0];
                end else if (!r_inhibit[k + 3]) begin
                    r_cnt[k] <= w_sum[k][CNT_WIDTH-1:0];
                end
                if (w_wr_evt[k]) begin
                    r_evsel[k] <= w_sel_wr;
                end
            end

            // mcountinhibit bit 1 is read-only zero
            if (we_i && (addr_i == HPM_INHIBIT_ADDR)) begin
                r_inhibit <= data_i[INH_W-1:0] & ~INH_W'(2);
            end

            // Set after clear so a same-cycle overflow survives the clear
            r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
        end
    end

`ifdef HPM_OVF_IRQ_EN
    logic [63:0] r_ovfen;
    logic        r_irq;

    // Interrupt enable register and registered interrupt
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovfen <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (we_i && (addr_i == HPM_OVFEN_ADDR)) begin
                r_ovfen <= data_i;
            end
            r_irq <= |(r_ovf & r_ovfen[NUM_COUNTERS-1:0]);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    // Read decode; unmapped addresses return 0
    always_comb begin
        w_rdata = '0;
        if (addr_i == HPM_MCYCLE_ADDR)   w_rdata = 64'(r_mcycle);
        if (addr_i == HPM_MINSTRET_ADDR) w_rdata = 64'(r_minstret);
        if (addr_i == HPM_INHIBIT_ADDR)  w_rdata = 64'(r_inhibit);
        if (addr_i == HPM_OVF_ADDR)      w_rdata = 64'(r_ovf);
`ifdef HPM_OVF_IRQ_EN
        if (addr_i == HPM_OVFEN_ADDR)    w_rdata = r_ovfen;
`endif
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            if (addr_i == HPM_CNT_BASE + 12'(k + 3)) w_rdata = 64'(r_cnt[k]);
            if (addr_i == HPM_EVT_BASE + 12'(k + 3)) w_rdata = 64'(r_evsel[k]);
        end
    end

    // Registered read data returns the pre-write value on a same-cycle write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign data_o = r_rdata;
    assign ovf_o  = r_ovf;

endmodule : hpm_counter_bank
`default_nettype wire
